// File: rtl/vga_dec_pkg.sv
// Shared types and constants for the VGA timing decoder.
package vga_dec_pkg;

  localparam int unsigned CNT_W           = 10;
  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_V_TOTAL     = 521;
  localparam int unsigned DEF_LOCK_FRAMES = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ACQUIRE,
    ST_LOCKED
  } dec_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Falling-edge detector for an active-low sync, sampled only on pixel-enable
// clocks. The sync history idles high after reset.
module sync_edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_pix_en,
  input  logic i_sync_n,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_prev <= 1'b1;
    end else if (i_pix_en) begin
      r_prev <= i_sync_n;
    end
  end

  assign o_fall = i_pix_en & r_prev & ~i_sync_n;

endmodule

// File: rtl/vga_timing_decoder.sv
// Measures VGA line/frame timing, locks onto the expected geometry and emits
// active-area pixels. Optional per-frame checksum: define VGA_DEC_CHECKSUM_EN.
module vga_timing_decoder
  import vga_dec_pkg::*;
#(
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hSync,
  input  logic             vSync,
  input  logic             vga_blank,
  input  logic [7:0]       RED,
  input  logic [7:0]       GREEN,
  input  logic [7:0]       BLUE,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic [23:0]      pixel_rgb,
  output logic             pixel_valid,
  output logic             line_start,
  output logic             frame_start,
  output logic             locked,
  output logic             timing_err,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total
`ifdef VGA_DEC_CHECKSUM_EN
  ,
  output logic [15:0]      frame_sum
`endif
);

  localparam logic [CNT_W-1:0] H_EXP  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] V_EXP  = CNT_W'(V_TOTAL);
  localparam logic [7:0]       LOCK_N = 8'(LOCK_FRAMES);

  logic             w_line_edge;
  logic             w_frame_edge;
  logic [CNT_W-1:0] w_h_meas;
  logic [CNT_W-1:0] w_v_meas;
  logic             w_h_bad;
  logic             w_v_bad;
  logic             w_wdog;
  logic             w_valid;
  logic [CNT_W-1:0] w_cur_x;
  logic [CNT_W-1:0] w_cur_y;

  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] r_xcnt;
  logic [CNT_W-1:0] r_ycnt;
  logic             r_line_active;
  dec_state_t       r_state;
  logic [7:0]       r_good_cnt;
  logic             r_frame_bad;

  sync_edge_detect u_hsync_edge (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_pix_en (pix_en),
    .i_sync_n (hSync),
    .o_fall   (w_line_edge)
  );

  sync_edge_detect u_vsync_edge (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_pix_en (pix_en),
    .i_sync_n (vSync),
    .o_fall   (w_frame_edge)
  );

  always_comb begin
    w_h_meas = r_hcnt + CNT_ONE;
    w_v_meas = r_vcnt + CNT_ONE;
    w_h_bad  = w_line_edge & (w_h_meas != H_EXP);
    w_v_bad  = w_frame_edge & (w_v_meas != V_EXP);
    // A counter parked at its ceiling trips the watchdog unless the edge that
    // would clear it arrives on this very pixel.
    w_wdog   = pix_en & (((r_hcnt == CNT_MAX) & ~w_line_edge) |
                         ((r_vcnt == CNT_MAX) & ~w_frame_edge));
    w_valid  = pix_en & vga_blank & locked;
    w_cur_x  = w_line_edge ? '0 : r_xcnt;
    if (w_frame_edge) begin
      w_cur_y = '0;
    end else if (w_line_edge && r_line_active) begin
      w_cur_y = r_ycnt + CNT_ONE;
    end else begin
      w_cur_y = r_ycnt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_xcnt        <= '0;
      r_ycnt        <= '0;
      r_line_active <= 1'b0;
      h_total       <= '0;
      v_total       <= '0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      pixel_rgb     <= '0;
    end else if (pix_en) begin
      if (w_line_edge) begin
        r_hcnt  <= '0;
        h_total <= w_h_meas;
      end else if (r_hcnt != CNT_MAX) begin
        r_hcnt <= r_hcnt + CNT_ONE;
      end
      if (w_frame_edge) begin
        r_vcnt  <= '0;
        v_total <= w_v_meas;
      end else if (w_line_edge && (r_vcnt != CNT_MAX)) begin
        r_vcnt <= r_vcnt + CNT_ONE;
      end
      r_xcnt        <= w_cur_x + (vga_blank ? CNT_ONE : '0);
      r_ycnt        <= w_cur_y;
      r_line_active <= (w_line_edge | w_frame_edge) ? vga_blank : (r_line_active | vga_blank);
      pixel_x       <= w_cur_x;
      pixel_y       <= w_cur_y;
      pixel_rgb     <= {RED, GREEN, BLUE};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= w_valid;
      line_start  <= w_line_edge;
      frame_start <= w_frame_edge;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SEARCH;
      r_good_cnt  <= '0;
      r_frame_bad <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      if (w_wdog) begin
        r_state    <= ST_SEARCH;
        locked     <= 1'b0;
        timing_err <= locked;
      end else begin
        case (r_state)
          ST_SEARCH: begin
            if (w_frame_edge) begin
              r_state     <= ST_ACQUIRE;
              r_good_cnt  <= '0;
              r_frame_bad <= 1'b0;
            end
          end
          ST_ACQUIRE: begin
            // The line edge coinciding with the frame edge closes the last
            // line of the frame being judged, so its length counts too.
            if (w_frame_edge) begin
              r_frame_bad <= 1'b0;
              if (r_frame_bad || w_h_bad || w_v_bad) begin
                r_good_cnt <= '0;
              end else if (r_good_cnt + 8'd1 == LOCK_N) begin
                r_state <= ST_LOCKED;
                locked  <= 1'b1;
              end else begin
                r_good_cnt <= r_good_cnt + 8'd1;
              end
            end else if (w_h_bad) begin
              r_frame_bad <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (w_h_bad || w_v_bad) begin
              r_state    <= ST_SEARCH;
              locked     <= 1'b0;
              timing_err <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_SEARCH;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] w_pix_sum;
  logic [15:0] r_acc;

  assign w_pix_sum = 16'(RED) + 16'(GREEN) + 16'(BLUE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      frame_sum <= '0;
    end else if (pix_en) begin
      if (w_frame_edge) begin
        frame_sum <= r_acc;
        r_acc     <= w_valid ? w_pix_sum : '0;
      end else if (w_valid) begin
        r_acc <= r_acc + w_pix_sum;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Scoreboard bench for vga_timing_decoder on a reduced 40x20 raster.
module tb_vga_timing_decoder;

  localparam int HT   = 40;
  localparam int VT   = 20;
  localparam int LF   = 2;
  localparam int HS_W = 4;
  localparam int VS_W = 2;
  localparam int AX0  = 8;
  localparam int AX1  = 35;
  localparam int AY0  = 3;
  localparam int AY1  = 17;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        hSync = 1'b1;
  logic        vSync = 1'b1;
  logic        vga_blank = 1'b0;
  logic [7:0]  RED = '0, GREEN = '0, BLUE = '0;
  logic [9:0]  pixel_x, pixel_y, h_total, v_total;
  logic [23:0] pixel_rgb;
  logic        pixel_valid, line_start, frame_start, locked, timing_err;
`ifdef VGA_DEC_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic [15:0] cur_sum = '0, prev_sum = '0;
`endif

  vga_timing_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF)) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
    .vga_blank(vga_blank), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
    .pixel_valid(pixel_valid), .line_start(line_start), .frame_start(frame_start),
    .locked(locked), .timing_err(timing_err), .h_total(h_total), .v_total(v_total)
`ifdef VGA_DEC_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   cur_lock = 1'b0;
  int   err_pulses = 0;

  logic       g_ls, g_fs, g_err, g_locked;
  logic [9:0] g_htot, g_vtot;

  always @(negedge clock) begin
    if (pixel_valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid x=%0d y=%0d rgb=%06h, no pixel expected", pixel_x, pixel_y, pixel_rgb);
      end else begin
        e = q.pop_front();
        if ({pixel_x, pixel_y, pixel_rgb} !== {e.x, e.y, e.rgb}) begin
          errors++;
          $display("FAIL pixel got x=%0d y=%0d rgb=%06h expected x=%0d y=%0d rgb=%06h",
                   pixel_x, pixel_y, pixel_rgb, e.x, e.y, e.rgb);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete, required finish");
    $fatal(1);
  end

  task automatic drive_pixel(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    hSync = hs; vSync = vs; vga_blank = blank; {RED, GREEN, BLUE} = rgb; pix_en = 1'b1;
    @(negedge clock);
    g_ls = line_start; g_fs = frame_start; g_err = timing_err; g_locked = locked;
    g_htot = h_total; g_vtot = v_total;
    if (timing_err) err_pulses++;
    pix_en = 1'b0; hSync = ~hs; vSync = ~vs; vga_blank = ~blank;
    @(negedge clock);
  endtask

  // Sends one raster frame (or its first max_pix pixels); a line of HT-1
  // pixels is inserted at short_line when short_line >= 0.
  task automatic send_frame(input int frame_idx, input int short_line, input bit lock_at_edge,
                            input bit check_meas, input int max_pix);
    int n = 0;
    for (int line = 0; line < VT; line++) begin
      int len = (line == short_line) ? HT - 1 : HT;
      for (int px = 0; px < len; px++) begin
        logic [23:0] rgb;
        bit act;
        if (n == max_pix) return;
        n++;
        act = (px >= AX0) && (px <= AX1) && (line >= AY0) && (line <= AY1);
        rgb = {8'(px), 8'(line), 8'(frame_idx) ^ 8'h5A};
        if (act && cur_lock) begin
          q.push_back(exp_t'{x: 10'(px - AX0), y: 10'(line - AY0), rgb: rgb});
`ifdef VGA_DEC_CHECKSUM_EN
          cur_sum = cur_sum + 16'(rgb[23:16]) + 16'(rgb[15:8]) + 16'(rgb[7:0]);
`endif
        end
        drive_pixel((px < HS_W) ? 1'b0 : 1'b1, (line < VS_W) ? 1'b0 : 1'b1, act, rgb);
        if (line == 0 && px == 0) begin
          checks++;
          if ({g_fs, g_ls, g_locked} !== {2'b11, lock_at_edge}) begin
            errors++;
            $display("FAIL frame_edge f=%0d got fs/ls/locked=%b%b%b expected 11%b",
                     frame_idx, g_fs, g_ls, g_locked, lock_at_edge);
          end
          cur_lock = lock_at_edge;
          if (check_meas) begin
            checks++;
            if (g_htot !== 10'(HT) || g_vtot !== 10'(VT)) begin
              errors++;
              $display("FAIL totals f=%0d got h=%0d v=%0d expected h=%0d v=%0d",
                       frame_idx, g_htot, g_vtot, HT, VT);
            end
          end
`ifdef VGA_DEC_CHECKSUM_EN
          checks++;
          if (frame_sum !== prev_sum) begin
            errors++;
            $display("FAIL frame_sum f=%0d got %04h expected %04h", frame_idx, frame_sum, prev_sum);
          end
          prev_sum = cur_sum;
          cur_sum  = '0;
`endif
        end
        if (line == 1 && px == 0) begin
          checks++;
          if ({g_fs, g_ls} !== 2'b01) begin
            errors++;
            $display("FAIL line_edge f=%0d got fs/ls=%b%b expected 01", frame_idx, g_fs, g_ls);
          end
        end
        if (short_line >= 0 && line == short_line + 1 && px == 0) begin
          checks++;
          if ({g_err, g_locked, g_htot} !== {1'b1, 1'b0, 10'(HT - 1)}) begin
            errors++;
            $display("FAIL short_line got err=%b locked=%b h=%0d expected err=1 locked=0 h=%0d",
                     g_err, g_locked, g_htot, HT - 1);
          end
          cur_lock = 1'b0;
        end
      end
    end
  endtask

  task automatic check_idle(input string name, input int err_before, input int err_exp);
    checks++;
    if (q.size() != 0 || err_pulses - err_before != err_exp) begin
      errors++;
      $display("FAIL %s got pending=%0d err_pulses=%0d expected pending=0 err_pulses=%0d",
               name, q.size(), err_pulses - err_before, err_exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({pixel_x, pixel_y, pixel_rgb, pixel_valid, line_start, frame_start, timing_err,
         h_total, v_total} !== '0) begin
      errors++;
      $display("FAIL %s outputs got x=%0d y=%0d rgb=%06h v/ls/fs/err=%b%b%b%b h=%0d v=%0d expected all 0",
               name, pixel_x, pixel_y, pixel_rgb, pixel_valid, line_start, frame_start,
               timing_err, h_total, v_total);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL %s locked got %b expected 0", name, locked);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_lock();
    int e0 = err_pulses;
    cur_lock = 1'b0;
    for (int f = 0; f < 5; f++) send_frame(f, -1, f >= 2, f >= 1, -1);
    check_idle("lock", e0, 0);
  endtask

  task automatic test_short_line();
    int e0 = err_pulses;
    send_frame(5, 5, 1'b1, 1'b1, -1);
    send_frame(6, -1, 1'b0, 1'b1, -1);
    send_frame(7, -1, 1'b0, 1'b1, -1);
    send_frame(8, -1, 1'b1, 1'b1, -1);
    check_idle("short_line", e0, 1);
  endtask

  task automatic test_watchdog();
    int e0 = err_pulses;
    int hit = -1;
    drive_pixel(1'b0, 1'b0, 1'b0, 24'h0);
    checks++;
    if ({g_fs, g_locked} !== 2'b11) begin
      errors++;
      $display("FAIL wdog_start got fs/locked=%b%b expected 11", g_fs, g_locked);
    end
    cur_lock = 1'b1;
    for (int i = 0; i < 1100 && hit < 0; i++) begin
      drive_pixel(1'b1, 1'b1, 1'b0, 24'h0);
      if (g_err) begin
        hit = i;
        checks++;
        if (g_locked !== 1'b0) begin
          errors++;
          $display("FAIL wdog_locked got %b expected 0", g_locked);
        end
      end
    end
    cur_lock = 1'b0;
    checks++;
    if (hit < 1000) begin
      errors++;
      $display("FAIL wdog_trip got pixel %0d expected error between 1000 and 1100", hit);
    end
    repeat (20) drive_pixel(1'b1, 1'b1, 1'b0, 24'h0);
    check_idle("wdog", e0, 1);
    e0 = err_pulses;
    send_frame(9, -1, 1'b0, 1'b0, -1);
    send_frame(10, -1, 1'b0, 1'b1, -1);
    send_frame(11, -1, 1'b1, 1'b1, -1);
    check_idle("wdog_relock", e0, 0);
  endtask

  task automatic test_reset_mid();
    int e0 = err_pulses;
    send_frame(12, -1, 1'b1, 1'b1, 5 * HT + 20);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_mid");
    cur_lock = 1'b0;
    q.delete();
`ifdef VGA_DEC_CHECKSUM_EN
    cur_sum = '0; prev_sum = '0;
`endif
    reset = 1'b0;
    @(negedge clock);
    send_frame(13, -1, 1'b0, 1'b0, -1);
    send_frame(14, -1, 1'b0, 1'b1, -1);
    send_frame(15, -1, 1'b1, 1'b1, -1);
    send_frame(16, -1, 1'b1, 1'b1, -1);
    check_idle("reset_relock", e0, 0);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_lock();
    test_short_line();
    test_watchdog();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
